diff_engine_mc: RTL and testbench
=================================

Name: diff_engine_mc

Overview:
Multi-channel streaming finite-difference engine. It accepts time-interleaved signed samples tagged with a channel number and keeps a per-channel backward-difference table. It emits difference orders 1..MAX_ORDER one beat at a time over a valid/ready stream. It sits after the sample capture path and feeds the recovery/estimation logic.

Parameters:
DATA_W, 16, sample and output width (signed)
MAX_ORDER, 4, highest difference order computed (>=1)
N_CH, 2, number of independent channels (>=1)
SATURATE, 1, 1 = saturate outputs to DATA_W; 0 = wrap (truncate to low bits)
CH_W, $clog2(N_CH) (min 1), channel tag width (derived)
ORD_W, $clog2(MAX_ORDER+1), order tag width (derived)
ACC_W, DATA_W+MAX_ORDER, internal table width (derived; exact, no overflow)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  sample present
in_ready  out  1  engine can accept a sample
in_ch  in  CH_W  channel of sample
in_data  in  DATA_W  signed sample
flush  in  1  clear all channel tables (honoured in IDLE only)
out_valid  out  1  difference beat present
out_ready  in  1  downstream accepts beat
out_ch  out  CH_W  channel of beat
out_order  out  ORD_W  difference order k of beat (1..MAX_ORDER)
out_data  out  DATA_W  signed k-th backward difference (saturated or wrapped)
out_last  out  1  final beat for this sample
busy  out  1  state != IDLE
ovf_sticky  out  1  set when an emitted value exceeded the DATA_W range; cleared by reset or flush

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values: all tables d[ch][0..MAX_ORDER]=0, cnt[ch]=0, state IDLE, out_valid=0, out_data=0, out_ch=0, out_order=0, out_last=0, busy=0, ovf_sticky=0.
- Reset mid-RUN: the in-flight sample is abandoned, out_valid=0 on the next cycle, and all tables are cleared.
- State table per channel: d[k] holds the k-th backward difference at the latest sample, ACC_W bits signed. cnt[ch] = samples previously accepted, saturating at MAX_ORDER.
- Handshake:
  - in_ready = (state==IDLE) && !flush.
  - A sample is accepted on in_valid && in_ready; out beats transfer on out_valid && out_ready.
  - While out_valid && !out_ready, all out_* signals are held stable.
- FSM IDLE: on accept at cycle T:
  - latch ch; compute n = cnt[ch];
  - prev_new <= sign-extended x; prev_old <= d[ch][0]; d[ch][0] <= x;
  - k <= 1; go to RUN.
- FSM RUN, step k:
  - new = prev_new - prev_old.
  - If k <= n: out_valid=1, out_order=k, out_data=fmt(new), out_last=(k==n). The step commits only on out_ready.
  - If k > n: the step commits without output.
  - On commit: d[ch][k] <= new; prev_old <= old d[ch][k]; prev_new <= new.
  - After committing k==MAX_ORDER: cnt[ch] <= min(cnt+1, MAX_ORDER); return to IDLE.
- Latency: order 1 is presented in cycle T+1 and order k in cycle T+k with no backpressure. The next sample can be accepted at T+MAX_ORDER+1.
- Priming: a sample emits orders 1..min(cnt,MAX_ORDER). The first sample on a channel emits no beats but still updates the table. Order k is exact once k+1 samples have been seen.
- fmt():
  - SATURATE=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - SATURATE=0: take the low DATA_W bits.
  - Either mode: ovf_sticky sets on a committed emitted beat whose new value is out of range.
- flush in IDLE: one cycle; zeroes all d and cnt and clears ovf_sticky; no sample is accepted that cycle. flush during RUN is ignored (the caller holds it until !busy).
- in_ch >= N_CH: the sample is accepted and discarded; no beats; no table change; state stays IDLE.
- Channels are fully independent. Interleaving order is arbitrary.

Decomposition:
- Package diff_engine_pkg: state enum {IDLE, RUN}; functions acc_w(DATA_W,MAX_ORDER) and sat_to(width, value).
- One sub-module diff_sat: parameters IN_W, OUT_W, SATURATE; combinational clamp/wrap with an overflow flag. It is instantiated once on the new-value path.
- Tables are a register array [N_CH][MAX_ORDER+1] indexed by the latched channel.

Test Plan (DATA_W=8, MAX_ORDER=3, N_CH=2, out_ready=1 unless stated):
1. ch0 samples 1,4,9,16 -> no beats; then (1,3,last); then (1,5),(2,2,last); then (1,7),(2,2),(3,0,last), each order k at T+k.
2. Interleave ch0=10, ch1=100, ch0=13, ch1=90 -> ch0 (1,3,last); ch1 (1,-10,last); no cross-channel contamination.
3. ch0 samples -128, 127 -> order1 = 255 gives out_data=127 and ovf_sticky=1; with SATURATE=0, out_data=-1 and ovf_sticky=1.
4. Primed ch0, drop out_ready for 5 cycles at the order-2 beat -> out_* stable, in_ready=0, busy=1; order 3 follows 1 cycle after out_ready returns.
5. flush with in_valid=1 in IDLE -> in_ready=0, ovf_sticky=0; the next ch0 sample emits no beats. reset asserted at RUN step 2 -> out_valid=0 next cycle, cnt cleared.
6. in_ch=3 (invalid) with data 50 -> accepted, no beats; the next valid ch0 sample result is unchanged versus a run without it.

Source files
------------

// File: rtl/diff_engine_pkg.sv
// Shared types and helpers for the multi-channel finite-difference engine.
package diff_engine_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Exact width of the difference table: each order can grow by one bit.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned max_order);
    return data_w + max_order;
  endfunction

  function automatic logic signed [63:0] sat_to(input int unsigned width,
                                                input logic signed [63:0] value);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/diff_sat.sv
// Narrows a signed value to OUT_W bits by clamping or wrapping, flagging out-of-range input.
module diff_sat
  import diff_engine_pkg::*;
#(
  parameter int unsigned IN_W     = 20,
  parameter int unsigned OUT_W    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout_c,
  output logic                    ovf_c
);

  logic signed [63:0] ext;
  logic signed [63:0] clamped;

  always_comb begin
    ext     = 64'(din);
    clamped = sat_to(OUT_W, ext);
    ovf_c   = (clamped != ext);
    dout_c  = SATURATE ? OUT_W'(clamped) : OUT_W'(din);
  end

endmodule

// File: rtl/diff_engine_mc.sv
// Per-channel backward-difference engine emitting orders 1..MAX_ORDER as a valid/ready stream.
module diff_engine_mc
  import diff_engine_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_ORDER = 4,
  parameter int unsigned N_CH      = 2,
  parameter bit          SATURATE  = 1'b1,
  parameter int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int unsigned ORD_W     = $clog2(MAX_ORDER + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [ORD_W-1:0]         out_order,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     ovf_sticky
);

  localparam int unsigned ACC_W = acc_w(DATA_W, MAX_ORDER);
  localparam int unsigned TBL_D = MAX_ORDER + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [ORD_W-1:0]   k_q, k_d, n_q, n_d;
  acc_t               cur_q, cur_d;
  acc_t               d_q [N_CH][TBL_D];
  acc_t               d_d [N_CH][TBL_D];
  logic [ORD_W-1:0]   cnt_q [N_CH];
  logic [ORD_W-1:0]   cnt_d [N_CH];
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [CH_W-1:0]    out_ch_q, out_ch_d;
  logic [ORD_W-1:0]   out_order_q, out_order_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic               ovf_beat_q, ovf_beat_d, ovf_sticky_q, ovf_sticky_d;

  logic               ch_ok_c, load_c, commit_c, fmt_ovf_c;
  logic [CH_W-1:0]    in_idx_c;
  acc_t               x_c, new_c;
  logic signed [DATA_W-1:0] fmt_data_c;

  // New difference for the step about to be presented: order 1 on accept, order k+1 on commit.
  always_comb begin
    ch_ok_c  = (32'(in_ch) < N_CH);
    in_idx_c = ch_ok_c ? in_ch : '0;
    x_c      = ACC_W'(in_data);
    if (state_q == IDLE) new_c = x_c - d_q[in_idx_c][0];
    else                 new_c = cur_q - d_q[ch_q][k_q];
  end

  diff_sat #(.IN_W(ACC_W), .OUT_W(DATA_W), .SATURATE(SATURATE)) u_sat (
    .din    (new_c),
    .dout_c (fmt_data_c),
    .ovf_c  (fmt_ovf_c)
  );

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    k_d          = k_q;
    n_d          = n_q;
    cur_d        = cur_q;
    d_d          = d_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    out_order_d  = out_order_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    ovf_beat_d   = ovf_beat_q;
    ovf_sticky_d = ovf_sticky_q;
    load_c       = 1'b0;
    commit_c     = !out_valid_q || out_ready;
    case (state_q)
      IDLE: begin
        if (flush) begin
          for (int c = 0; c < N_CH; c++) begin
            cnt_d[c] = '0;
            for (int j = 0; j < TBL_D; j++) d_d[c][j] = '0;
          end
          ovf_sticky_d = 1'b0;
        end else if (in_valid && ch_ok_c) begin
          ch_d              = in_idx_c;
          n_d               = cnt_q[in_idx_c];
          k_d               = ORD_W'(1);
          d_d[in_idx_c][0]  = x_c;
          cur_d             = new_c;
          state_d           = RUN;
          load_c            = 1'b1;
        end
      end
      RUN: begin
        if (commit_c) begin
          d_d[ch_q][k_q] = cur_q;
          if (out_valid_q && ovf_beat_q) ovf_sticky_d = 1'b1;
          if (k_q == ORD_W'(MAX_ORDER)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            if (cnt_q[ch_q] != ORD_W'(MAX_ORDER)) cnt_d[ch_q] = cnt_q[ch_q] + ORD_W'(1);
          end else begin
            k_d    = k_q + ORD_W'(1);
            cur_d  = new_c;
            load_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Orders beyond the channel's sample count are computed silently.
    if (load_c) begin
      out_valid_d = (k_d <= n_d);
      out_ch_d    = ch_d;
      out_order_d = k_d;
      out_data_d  = fmt_data_c;
      out_last_d  = (k_d == n_d);
      ovf_beat_d  = fmt_ovf_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      k_q          <= '0;
      n_q          <= '0;
      cur_q        <= '0;
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c] <= '0;
        for (int j = 0; j < TBL_D; j++) d_q[c][j] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_order_q  <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      ovf_beat_q   <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      k_q          <= k_d;
      n_q          <= n_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_order_q  <= out_order_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      ovf_beat_q   <= ovf_beat_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && !flush;
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_order  = out_order_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_diff_engine_mc.sv
// Scoreboard bench: saturating and wrapping engines share stimulus; monitors pop expected beats.
module tb_diff_engine_mc;

  // Three channels so that tag 3 is representable yet out of range.
  localparam int unsigned DW = 8;
  localparam int unsigned MO = 3;
  localparam int unsigned NC = 3;

  logic clk = 1'b0;
  logic reset, in_valid, flush, out_ready;
  logic [1:0] in_ch;
  logic signed [DW-1:0] in_data;

  logic in_ready_s, out_valid_s, out_last_s, busy_s, ovf_s;
  logic [1:0] out_ch_s, out_order_s;
  logic signed [DW-1:0] out_data_s;
  logic in_ready_w, out_valid_w, out_last_w, busy_w, ovf_w;
  logic [1:0] out_ch_w, out_order_w;
  logic signed [DW-1:0] out_data_w;

  typedef struct {
    int ch; int order; int sat; int wrap; int last; int cyc;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  diff_engine_mc #(.DATA_W(DW), .MAX_ORDER(MO), .N_CH(NC), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .in_ch(in_ch),
    .in_data(in_data), .flush(flush), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_ch(out_ch_s), .out_order(out_order_s), .out_data(out_data_s), .out_last(out_last_s),
    .busy(busy_s), .ovf_sticky(ovf_s)
  );

  diff_engine_mc #(.DATA_W(DW), .MAX_ORDER(MO), .N_CH(NC), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w), .in_ch(in_ch),
    .in_data(in_data), .flush(flush), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_ch(out_ch_w), .out_order(out_order_w), .out_data(out_data_w), .out_last(out_last_w),
    .busy(busy_w), .ovf_sticky(ovf_w)
  );

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int ch, input int order, input int s, input int w,
                      input int last, input int at);
    exp_t e;
    e = '{ch: ch, order: order, sat: s, wrap: w, last: last, cyc: at};
    q_s.push_back(e);
    q_w.push_back(e);
  endtask

  always @(negedge clk) begin : mon_sat
    exp_t e;
    if (!reset && out_valid_s && out_ready) begin
      if (q_s.size() == 0) check("sat_extra_beat", out_order_s, 0);
      else begin
        e = q_s.pop_front();
        check("sat_ch", out_ch_s, e.ch);
        check("sat_order", out_order_s, e.order);
        check("sat_data", out_data_s, e.sat);
        check("sat_last", out_last_s, e.last);
        if (e.cyc >= 0) check("sat_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_wrap
    exp_t e;
    if (!reset && out_valid_w && out_ready) begin
      if (q_w.size() == 0) check("wrap_extra_beat", out_order_w, 0);
      else begin
        e = q_w.pop_front();
        check("wrap_beat", {out_ch_w, out_order_w, out_last_w}, {2'(e.ch), 2'(e.order), 1'(e.last)});
        check("wrap_data", out_data_w, e.wrap);
      end
    end
  end

  task automatic send(input int ch, input int data);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_ch = 2'(ch); in_data = 8'(data); in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_s) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    t_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy_s) begin done = 1'b1; break; end
    end
    check("idle_reached", done, 1);
    check("beats_pending", q_s.size() + q_w.size(), 0);
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_ch = 2'd0; in_data = 8'sd77;
    @(negedge clk);
    check("flush_in_ready", {in_ready_s, in_ready_w}, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_ovf", {ovf_s, ovf_w}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_ch = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outs", {out_valid_s, out_ch_s, out_order_s, out_data_s, out_last_s}, 0);
    check("rst_status", {busy_s, ovf_s, busy_w, ovf_w}, 0);
    check("rst_in_ready", {in_ready_s, in_ready_w}, 2'b11);

    // Squares on ch0: differences settle to 2 and 0.
    send(0, 1);  wait_idle();
    send(0, 4);  push(0, 1, 3, 3, 1, t_acc + 1); wait_idle();
    send(0, 9);  push(0, 1, 5, 5, 0, t_acc + 1); push(0, 2, 2, 2, 1, t_acc + 2); wait_idle();
    send(0, 16); push(0, 1, 7, 7, 0, t_acc + 1); push(0, 2, 2, 2, 0, t_acc + 2);
                 push(0, 3, 0, 0, 1, t_acc + 3); wait_idle();
    check("sq_no_ovf", ovf_s, 0);

    // Backpressure on the order-2 beat for five cycles.
    send(0, 25);
    push(0, 1, 9, 9, 0, t_acc + 1); push(0, 2, 2, 2, 0, t_acc + 7); push(0, 3, 0, 0, 1, t_acc + 8);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_beat", {out_valid_s, out_ch_s, out_order_s, out_data_s, out_last_s},
            {1'b1, 2'd0, 2'd2, 8'd2, 1'b0});
      check("stall_in_ready", in_ready_s, 0);
      check("stall_busy", busy_s, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // Interleaved channels stay independent.
    do_flush();
    send(0, 10);  wait_idle();
    send(1, 100); wait_idle();
    send(0, 13);  push(0, 1, 3, 3, 1, t_acc + 1); wait_idle();
    send(1, 90);  push(1, 1, -10, -10, 1, t_acc + 1); wait_idle();

    // Order-1 of 255 overflows an 8-bit output.
    do_flush();
    send(0, -128); wait_idle();
    check("ovf_before", {ovf_s, ovf_w}, 0);
    send(0, 127); push(0, 1, 127, -1, 1, t_acc + 1); wait_idle();
    check("ovf_sat", ovf_s, 1);
    check("ovf_wrap", ovf_w, 1);

    // Flush with a sample offered: sample dropped, ch0 restarts unprimed.
    do_flush();
    send(0, 5); wait_idle();
    send(0, 8); push(0, 1, 3, 3, 1, t_acc + 1); wait_idle();

    // Reset during order-2 step abandons the sample and clears tables.
    send(0, 20); push(0, 1, 12, 12, 0, t_acc + 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("pre_reset_order", {out_valid_s, out_order_s}, {1'b1, 2'd2});
    @(negedge clk);
    check("reset_out_valid", {out_valid_s, out_valid_w}, 0);
    check("reset_busy", busy_s, 0);
    reset = 1'b0;
    send(0, 30); wait_idle();

    // Out-of-range channel is swallowed without touching ch0.
    send(3, 50);
    @(negedge clk);
    check("bad_ch_busy", busy_s, 0);
    check("bad_ch_valid", out_valid_s, 0);
    wait_idle();
    send(0, 34); push(0, 1, 4, 4, 1, t_acc + 1); wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
